// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - microcode next-address sequencer with dispatch tables,
// illegal-opcode trap and retired-instruction counter.
module micro_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [1:0]       addr_ctl,
  input  logic             stall,
  output logic [3:0]       upc,
  output logic             instr_start,
  output logic             illegal,
  output logic             illegal_sticky,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEMADR    = 4'd2,
    MEMREAD   = 4'd3,
    MEMWB     = 4'd4,
    MEMWRITE  = 4'd5,
    EXECUTER  = 4'd6,
    ALUWB     = 4'd7,
    EXECUTEI  = 4'd8,
    JAL       = 4'd9,
    BEQ       = 4'd10
  } state_t;

  localparam logic [1:0] AC_SEQ   = 2'b00;
  localparam logic [1:0] AC_DISP1 = 2'b01;
  localparam logic [1:0] AC_DISP2 = 2'b10;
  localparam logic [1:0] AC_FETCH = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state;
  state_t d1_target;
  state_t d2_target;
  logic   d1_hit;
  logic   d2_hit;
  logic   unused_code;

  always_comb begin
    d1_hit    = 1'b1;
    d1_target = FETCH;
    case (op)
      7'b0110011: d1_target = EXECUTER;
      7'b0010011: d1_target = EXECUTEI;
      7'b1101111: d1_target = JAL;
      7'b1100011: d1_target = BEQ;
      7'b0000011: d1_target = MEMADR;
      7'b0100011: d1_target = MEMADR;
      default:    d1_hit    = 1'b0;
    endcase
  end

  always_comb begin
    d2_hit    = 1'b1;
    d2_target = FETCH;
    case (op)
      7'b0000011: d2_target = MEMREAD;
      7'b0100011: d2_target = MEMWRITE;
      default:    d2_hit    = 1'b0;
    endcase
  end

  // Codes 11-15 have no microword; they always fall back to Fetch.
  assign unused_code = (state > BEQ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= FETCH;
      illegal        <= 1'b0;
      illegal_sticky <= 1'b0;
      retired        <= '0;
    end else if (stall) begin
      illegal <= 1'b0;
    end else begin
      illegal <= 1'b0;
      if (unused_code) begin
        state <= FETCH;
      end else begin
        case (addr_ctl)
          AC_SEQ: state <= state_t'(state + 4'd1);
          AC_DISP1: begin
            state <= d1_target;
            if (!d1_hit) begin
              illegal        <= 1'b1;
              illegal_sticky <= 1'b1;
            end
          end
          AC_DISP2: begin
            state <= d2_target;
            if (!d2_hit) begin
              illegal        <= 1'b1;
              illegal_sticky <= 1'b1;
            end
          end
          AC_FETCH: begin
            state   <= FETCH;
            retired <= retired + CNT_ONE;
          end
          default: state <= FETCH;
        endcase
      end
    end
  end

  assign upc         = state;
  assign instr_start = (state == FETCH) && !stall;

endmodule
